// File: rtl/edge_detect_pkg.sv
//------------------------------------------------------------------------------
// edge_detect_pkg
// Shared constants and helpers for the multi-channel edge detector.
//   DEF_*       : default parameter values used by the interface and modules
//   clog2_min1  : counter width helper, never returns less than 1 bit
//------------------------------------------------------------------------------
`timescale 1ns/100ps
package edge_detect_pkg;

    localparam int   DEF_CH_NUM      = 4;
    localparam int   DEF_SYNC_STAGES = 2;
    localparam int   DEF_FILTER_LEN  = 4;
    localparam logic DEF_INIT_LEVEL  = 1'b0;

    // FILTER_LEN=1 still needs a 1-bit counter so the compare stays legal.
    function automatic int clog2_min1(input int v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/edge_detect_multi_if.sv
//------------------------------------------------------------------------------
// edge_detect_multi_if
// Channel-vector bundle between the edge detector and its user.
//   data_i      : raw input per channel
//   clr_i       : clear sticky flags per channel
//   level_o     : filtered, registered level
//   pos/neg/both_edge_o : 1-cycle edge pulses
//   pos/neg_flag_o      : sticky edge flags
// master = the user side (drives data/clr), slave = the detector.
//------------------------------------------------------------------------------
`timescale 1ns/100ps
interface edge_detect_multi_if
    import edge_detect_pkg::*;
#(
    parameter int CH_NUM = DEF_CH_NUM
);
    logic [CH_NUM-1:0] data_i;
    logic [CH_NUM-1:0] clr_i;
    logic [CH_NUM-1:0] level_o;
    logic [CH_NUM-1:0] pos_edge_o;
    logic [CH_NUM-1:0] neg_edge_o;
    logic [CH_NUM-1:0] both_edge_o;
    logic [CH_NUM-1:0] pos_flag_o;
    logic [CH_NUM-1:0] neg_flag_o;

    modport master (
        output data_i, clr_i,
        input  level_o, pos_edge_o, neg_edge_o, both_edge_o, pos_flag_o, neg_flag_o
    );

    modport slave (
        input  data_i, clr_i,
        output level_o, pos_edge_o, neg_edge_o, both_edge_o, pos_flag_o, neg_flag_o
    );
endinterface

// File: rtl/edge_filter_ch.sv
//------------------------------------------------------------------------------
// edge_filter_ch
// One channel: synchroniser chain, stability-counter debounce, registered
// level, 1-cycle pos/neg pulses and sticky software-clearable flags.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset
//   i_data         : raw (possibly asynchronous) input
//   i_clr          : clear sticky flags (level, sampled every cycle)
//   o_level        : filtered level
//   o_pos_edge     : pulse on accepted 0->1
//   o_neg_edge     : pulse on accepted 1->0
//   o_pos_flag     : sticky pos-edge flag
//   o_neg_flag     : sticky neg-edge flag
//------------------------------------------------------------------------------
`timescale 1ns/100ps
module edge_filter_ch
    import edge_detect_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   FILTER_LEN  = DEF_FILTER_LEN,
    parameter logic INIT_LEVEL  = DEF_INIT_LEVEL
)(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic i_data,
    input  logic i_clr,
    output logic o_level,
    output logic o_pos_edge,
    output logic o_neg_edge,
    output logic o_pos_flag,
    output logic o_neg_flag
);

    localparam int             CNT_W    = clog2_min1(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic w_s;   // synchronised sample fed to the filter

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = i_data;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_sync <= {SYNC_STAGES{INIT_LEVEL}};
                end else begin
                    r_sync[0] <= i_data;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_sync[i] <= r_sync[i-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pos_edge;
    logic             r_neg_edge;
    logic             r_pos_flag;
    logic             r_neg_flag;

    logic w_diff;
    logic w_accept;
    logic w_pos_next;
    logic w_neg_next;

    // A change is accepted on the FILTER_LEN-th consecutive differing sample;
    // any sample equal to the current level restarts the count.
    assign w_diff     = (w_s != r_level);
    assign w_accept   = w_diff && (r_cnt == CNT_LAST);
    assign w_pos_next = w_accept &  w_s;
    assign w_neg_next = w_accept & ~w_s;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_level    <= INIT_LEVEL;
            r_cnt      <= '0;
            r_pos_edge <= 1'b0;
            r_neg_edge <= 1'b0;
            r_pos_flag <= 1'b0;
            r_neg_flag <= 1'b0;
        end else begin
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_s;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_pos_edge <= w_pos_next;
            r_neg_edge <= w_neg_next;
            // Set has priority over a simultaneous clear so no edge is lost.
            r_pos_flag <= (r_pos_flag & ~i_clr) | w_pos_next;
            r_neg_flag <= (r_neg_flag & ~i_clr) | w_neg_next;
        end
    end

    assign o_level    = r_level;
    assign o_pos_edge = r_pos_edge;
    assign o_neg_edge = r_neg_edge;
    assign o_pos_flag = r_pos_flag;
    assign o_neg_flag = r_neg_flag;

endmodule

// File: rtl/edge_detect_multi.sv
//------------------------------------------------------------------------------
// edge_detect_multi
// CH_NUM independent debounced edge detectors. Each channel synchronises its
// input, filters it and reports level, edge pulses and sticky flags.
// Ports:
//   clk_i   : system clock (rising edge)
//   rst_n_i : asynchronous active-low reset
//   bus     : slave side of edge_detect_multi_if (data_i, clr_i in;
//             level/pulse/flag vectors out)
//------------------------------------------------------------------------------
`timescale 1ns/100ps
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int   CH_NUM      = DEF_CH_NUM,
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int   FILTER_LEN  = DEF_FILTER_LEN,
    parameter logic INIT_LEVEL  = DEF_INIT_LEVEL
)(
    input  logic               clk_i,
    input  logic               rst_n_i,
    edge_detect_multi_if.slave bus
);

    logic [CH_NUM-1:0] w_level;
    logic [CH_NUM-1:0] w_pos_edge;
    logic [CH_NUM-1:0] w_neg_edge;
    logic [CH_NUM-1:0] w_pos_flag;
    logic [CH_NUM-1:0] w_neg_flag;

    generate
        for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
            edge_filter_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .FILTER_LEN  (FILTER_LEN),
                .INIT_LEVEL  (INIT_LEVEL)
            ) u_ch (
                .clk_i      (clk_i),
                .rst_n_i    (rst_n_i),
                .i_data     (bus.data_i[g]),
                .i_clr      (bus.clr_i[g]),
                .o_level    (w_level[g]),
                .o_pos_edge (w_pos_edge[g]),
                .o_neg_edge (w_neg_edge[g]),
                .o_pos_flag (w_pos_flag[g]),
                .o_neg_flag (w_neg_flag[g])
            );
        end
    endgenerate

    assign bus.level_o     = w_level;
    assign bus.pos_edge_o  = w_pos_edge;
    assign bus.neg_edge_o  = w_neg_edge;
    // Both pulses are registered, so the OR is still a clean 1-cycle pulse.
    assign bus.both_edge_o = w_pos_edge | w_neg_edge;
    assign bus.pos_flag_o  = w_pos_flag;
    assign bus.neg_flag_o  = w_neg_flag;

endmodule

// File: tb/tb_edge_detect_multi.sv
`timescale 1ns/100ps
module tb_edge_detect_multi;
    import edge_detect_pkg::*;

    localparam int NCH = 4;
    localparam int SA  = 2;   // sync stages of DUT A
    localparam int FA  = 4;   // filter length of DUT A

    logic clk_a = 1'b0;
    logic clk_b = 1'b0;
    logic rst_na = 1'b0;
    logic rst_nb = 1'b0;

    always #5   clk_a = ~clk_a;
    always #2.5 clk_b = ~clk_b;

    edge_detect_multi_if #(.CH_NUM(NCH)) ifa();
    edge_detect_multi_if #(.CH_NUM(1))   ifb();

    edge_detect_multi #(
        .CH_NUM(NCH), .SYNC_STAGES(SA), .FILTER_LEN(FA), .INIT_LEVEL(1'b0)
    ) dut_a (
        .clk_i(clk_a), .rst_n_i(rst_na), .bus(ifa)
    );

    edge_detect_multi #(
        .CH_NUM(1), .SYNC_STAGES(0), .FILTER_LEN(1), .INIT_LEVEL(1'b1)
    ) dut_b (
        .clk_i(clk_b), .rst_n_i(rst_nb), .bus(ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] a_out;
    assign a_out = {ifa.level_o, ifa.pos_edge_o, ifa.neg_edge_o,
                    ifa.both_edge_o, ifa.pos_flag_o, ifa.neg_flag_o};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: raw samples are delayed SA edges, then a level change is
    // accepted once the last FA delayed samples all differ from the level.
    logic m_dl   [NCH][SA];
    logic m_hist [NCH][FA];
    logic [NCH-1:0] m_lvl, m_pos, m_neg, m_pf, m_nf;

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            for (int i = 0; i < SA; i++) m_dl[n][i] = 1'b0;
            for (int i = 0; i < FA; i++) m_hist[n][i] = 1'b0;
        end
        m_lvl = '0; m_pos = '0; m_neg = '0; m_pf = '0; m_nf = '0;
    endtask

    task automatic model_step(input logic [NCH-1:0] d, input logic [NCH-1:0] c);
        logic s, acc;
        for (int n = 0; n < NCH; n++) begin
            s = m_dl[n][SA-1];
            for (int i = SA-1; i > 0; i--) m_dl[n][i] = m_dl[n][i-1];
            m_dl[n][0] = d[n];
            for (int i = FA-1; i > 0; i--) m_hist[n][i] = m_hist[n][i-1];
            m_hist[n][0] = s;
            acc = 1'b1;
            for (int i = 0; i < FA; i++) if (m_hist[n][i] == m_lvl[n]) acc = 1'b0;
            m_pos[n] = acc & s;
            m_neg[n] = acc & ~s;
            if (acc) m_lvl[n] = s;
            m_pf[n] = (m_pf[n] & ~c[n]) | m_pos[n];
            m_nf[n] = (m_nf[n] & ~c[n]) | m_neg[n];
        end
    endtask

    // One clock of DUT A: apply, clock, step model, compare everything.
    task automatic cyc(input logic [NCH-1:0] d, input logic [NCH-1:0] c);
        ifa.data_i = d;
        ifa.clr_i  = c;
        @(posedge clk_a);
        #1;
        model_step(d, c);
        chk("model", a_out, {m_lvl, m_pos, m_neg, m_pos | m_neg, m_pf, m_nf});
    endtask

    task automatic do_reset_a();
        rst_na = 1'b0;
        ifa.data_i = '0;
        ifa.clr_i  = '0;
        model_reset();
        @(posedge clk_a);
        #1;
        chk("reset", a_out, 24'h0);
        @(posedge clk_a);
        #1;
        rst_na = 1'b1;
    endtask

    typedef struct {
        logic [NCH-1:0] d, c, lvl, pos, neg, pf, nf;
    } vec_t;
    vec_t tbl [10];

    int first_pos [NCH];
    int first_neg [NCH];
    int npulse;
    logic [NCH-1:0] cur, cc;
    logic [NCH-1:0] vd;
    int hold [NCH];

    logic b_prev, b_d;
    int   b_npos, b_nneg;

    task automatic clr_firsts();
        for (int n = 0; n < NCH; n++) begin
            first_pos[n] = -1;
            first_neg[n] = -1;
        end
    endtask

    task automatic note_edges(input int k);
        for (int n = 0; n < NCH; n++) begin
            if (ifa.pos_edge_o[n] && first_pos[n] < 0) first_pos[n] = k;
            if (ifa.neg_edge_o[n] && first_neg[n] < 0) first_neg[n] = k;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.data_i = '0;
        ifa.clr_i  = '0;
        ifb.data_i = 1'b1;
        ifb.clr_i  = 1'b0;

        // Test 1: table of a held rise on ch0, clear on the last row.
        for (int i = 0; i < 10; i++) begin
            tbl[i].d   = 4'b0001;
            tbl[i].c   = (i == 9) ? 4'b0001 : 4'b0000;
            tbl[i].lvl = (i >= 5) ? 4'b0001 : 4'b0000;
            tbl[i].pos = (i == 5) ? 4'b0001 : 4'b0000;
            tbl[i].neg = 4'b0000;
            tbl[i].pf  = (i >= 5 && i < 9) ? 4'b0001 : 4'b0000;
            tbl[i].nf  = 4'b0000;
        end
        do_reset_a();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].d, tbl[i].c);
            chk($sformatf("tbl%0d", i), a_out,
                {tbl[i].lvl, tbl[i].pos, tbl[i].neg, tbl[i].pos | tbl[i].neg,
                 tbl[i].pf, tbl[i].nf});
        end

        // Test 2: 3-cycle glitch rejected, 4-cycle pulse accepted both ways.
        do_reset_a();
        npulse = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc((k <= 3) ? 4'b0010 : 4'b0000, 4'b0000);
            npulse += int'(ifa.both_edge_o[1]);
        end
        chk("glitch_pulses", npulse, 0);
        chk("glitch_lvl_flags", {ifa.level_o[1], ifa.pos_flag_o[1], ifa.neg_flag_o[1]}, 3'b000);
        clr_firsts();
        for (int k = 1; k <= 14; k++) begin
            cyc((k <= 4) ? 4'b0010 : 4'b0000, 4'b0000);
            note_edges(k);
        end
        chk("min_pos_edge", first_pos[1], 6);
        chk("min_neg_edge", first_neg[1], 10);
        chk("min_final", {ifa.level_o[1], ifa.neg_flag_o[1]}, 2'b01);

        // Test 3: clear coincident with a new edge loses to the set.
        do_reset_a();
        for (int k = 1; k <= 8; k++) begin
            cyc(4'b0100, (k == 6 || k == 7) ? 4'b0100 : 4'b0000);
            if (k == 6) chk("clr_vs_set", {ifa.pos_edge_o[2], ifa.pos_flag_o[2]}, 2'b11);
            if (k == 7) chk("clr_after", ifa.pos_flag_o[2], 1'b0);
        end

        // Test 4: simultaneous toggles with hold times 2/4/6/8.
        do_reset_a();
        hold[0] = 2; hold[1] = 4; hold[2] = 6; hold[3] = 8;
        clr_firsts();
        for (int k = 1; k <= 20; k++) begin
            for (int n = 0; n < NCH; n++) vd[n] = (k <= hold[n]);
            cyc(vd, 4'b0000);
            note_edges(k);
        end
        chk("multi_pos0", first_pos[0], -1);
        chk("multi_neg0", first_neg[0], -1);
        chk("multi_pos1", first_pos[1], 6);
        chk("multi_pos2", first_pos[2], 6);
        chk("multi_pos3", first_pos[3], 6);
        chk("multi_neg1", first_neg[1], 10);
        chk("multi_neg2", first_neg[2], 12);
        chk("multi_neg3", first_neg[3], 14);

        // Test 5: reset while ch0 is mid-count (cnt=2), ch1 already accepted.
        do_reset_a();
        for (int k = 1; k <= 9; k++) cyc((k <= 5) ? 4'b0010 : 4'b0011, 4'b0000);
        chk("pre_rst_lvl", ifa.level_o, 4'b0010);
        rst_na = 1'b0;
        #1;
        chk("rst_async", a_out, 24'h0);
        model_reset();
        @(posedge clk_a); #1;
        @(posedge clk_a); #1;
        rst_na = 1'b1;
        clr_firsts();
        for (int k = 1; k <= 8; k++) begin
            cyc(4'b0011, 4'b0000);
            note_edges(k);
        end
        chk("rst_relat0", first_pos[0], 6);
        chk("rst_relat1", first_pos[1], 6);

        // Randomised run against the model.
        do_reset_a();
        cur = '0;
        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < NCH; n++) begin
                if ($urandom_range(0, 4) == 0) cur[n] = ~cur[n];
                cc[n] = ($urandom_range(0, 9) == 0);
            end
            cyc(cur, cc);
        end

        // Test 6: unsynchronised, unfiltered, INIT_LEVEL=1 instance.
        chk("b_reset", {ifb.level_o, ifb.pos_edge_o, ifb.neg_edge_o,
                        ifb.both_edge_o, ifb.pos_flag_o, ifb.neg_flag_o}, 6'b100000);
        @(posedge clk_b);
        #1;
        rst_nb = 1'b1;
        b_prev = 1'b1;
        b_npos = 0;
        b_nneg = 0;
        fork
            begin
                #0.2;
                repeat (10) begin
                    #12;
                    ifb.data_i = ~ifb.data_i;
                end
            end
            begin
                repeat (28) begin
                    @(posedge clk_b);
                    b_d = ifb.data_i[0];
                    #1;
                    chk("b_edge", {ifb.level_o, ifb.pos_edge_o, ifb.neg_edge_o, ifb.both_edge_o},
                        {b_d, b_d & ~b_prev, ~b_d & b_prev, b_d ^ b_prev});
                    b_npos += int'(ifb.pos_edge_o[0]);
                    b_nneg += int'(ifb.neg_edge_o[0]);
                    b_prev = b_d;
                end
            end
        join
        chk("b_npos", b_npos, 5);
        chk("b_nneg", b_nneg, 5);
        chk("b_flags", {ifb.pos_flag_o, ifb.neg_flag_o}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
